// File: rtl/aibio_dqs_dcs_pkg.sv
// Shared types and constants for the DQS duty-cycle-sensor calibration controller.
//   state_e  : controller FSM states
//   dec_e    : outcome of one averaged measurement
//   SRST_CYC : cycles the sensor is held in reset before the first measurement
package aibio_dqs_dcs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SRST,
    MEAS,
    DECIDE,
    DONE,
    TRACK
  } state_e;

  typedef enum logic [1:0] {
    DEC_TIE,
    DEC_HI,
    DEC_LO
  } dec_e;

  localparam int SRST_CYC = 4;

endpackage

// File: rtl/aibio_dqs_dcs_meas.sv
// One chopped duty-cycle measurement.
// After `start`, the window runs 2*SETTLE_CYC + 2^AVG_W cycles:
//   settle (chop=0), N/2 samples (chop=0), settle (chop=1), N/2 samples (chop=1).
// The ones count is accumulated only in sample cycles.
// Ports:
//   clk, reset : controller clock, synchronous active-high reset
//   start      : pulse on the edge that begins a measurement
//   dc_gt_50   : registered sensor decision, summed in sample cycles
//   chopen     : registered sensor chop control
//   done       : high in the final sample cycle of the window
//   hi / lo    : valid with done; ones count (incl. final sample) above / below N/2
module aibio_dqs_dcs_meas #(
  parameter int AVG_W      = 4,
  parameter int SETTLE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic dc_gt_50,
  output logic chopen,
  output logic done,
  output logic hi,
  output logic lo
);

  localparam int N      = 1 << AVG_W;
  localparam int HALF_N = N / 2;
  localparam int LEN    = 2 * SETTLE_CYC + N;
  localparam int CW     = $clog2(LEN);

  localparam logic [CW-1:0] WIN0_LO = CW'(SETTLE_CYC);
  // Last sample of the first half; chop flips on this edge.
  localparam logic [CW-1:0] WIN0_HI = CW'(SETTLE_CYC + HALF_N - 1);
  localparam logic [CW-1:0] WIN1_LO = CW'(2 * SETTLE_CYC + HALF_N);
  localparam logic [CW-1:0] LAST    = CW'(LEN - 1);
  localparam logic [AVG_W:0] HALF   = (AVG_W + 1)'(HALF_N);

  logic            active_q, active_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            chop_q, chop_d;
  logic [AVG_W:0]  ones_q, ones_d;
  logic            sample;
  logic            last;
  logic [AVG_W:0]  ones_sum;

  always_comb begin
    sample   = active_q && (((cnt_q >= WIN0_LO) && (cnt_q <= WIN0_HI)) || (cnt_q >= WIN1_LO));
    ones_sum = ones_q + {{AVG_W{1'b0}}, sample & dc_gt_50};
    last     = active_q && (cnt_q == LAST);

    active_d = active_q;
    cnt_d    = cnt_q;
    chop_d   = chop_q;
    ones_d   = ones_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      chop_d   = 1'b0;
      ones_d   = '0;
    end else if (active_q) begin
      cnt_d  = cnt_q + CW'(1);
      ones_d = ones_sum;
      if (cnt_q == WIN0_HI) chop_d = 1'b1;
      // The verdict is taken from ones_sum this cycle, so the accumulator and
      // chop are already clear during the controller's decide cycle.
      if (last) begin
        active_d = 1'b0;
        cnt_d    = '0;
        chop_d   = 1'b0;
        ones_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      chop_q   <= 1'b0;
      ones_q   <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      chop_q   <= chop_d;
      ones_q   <= ones_d;
    end
  end

  assign chopen = chop_q;
  assign done   = last;
  assign hi     = last && (ones_sum > HALF);
  assign lo     = last && (ones_sum < HALF);

endmodule

// File: rtl/aibio_dqs_dcs_cal_ctrl.sv
// DQS duty-cycle calibration controller.
// Resets the DCS sensor, then runs a SAR binary search on the DCC trim code using
// chopped, averaged sensor decisions. Optionally follows with +/-1 tracking.
// Ports:
//   clk, reset        : controller clock, synchronous active-high reset
//   cal_start         : single-cycle start request (ignored while busy)
//   track_en          : continue with tracking after the search
//   cfg_clkdiv        : sensor divider, captured into dcs_clkdiv at start
//   dc_gt_50          : registered sensor decision
//   dcs_en/dcs_reset/chopen/dcs_clkdiv : sensor controls (all registered)
//   dcc_code          : trim code to the DCC
//   cal_busy/cal_done/cal_err : status
module aibio_dqs_dcs_cal_ctrl #(
  parameter int CODE_W     = 7,
  parameter int AVG_W      = 4,
  parameter int SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cal_start,
  input  logic              track_en,
  input  logic [1:0]        cfg_clkdiv,
  input  logic              dc_gt_50,
  output logic              dcs_en,
  output logic              dcs_reset,
  output logic              chopen,
  output logic [1:0]        dcs_clkdiv,
  output logic [CODE_W-1:0] dcc_code,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_err
);

  import aibio_dqs_dcs_pkg::*;

  localparam int IW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [CODE_W-1:0] CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};

  state_e            state_q, state_d;
  logic [1:0]        srst_cnt_q, srst_cnt_d;
  logic [IW-1:0]     bit_q, bit_d;
  logic [CODE_W-1:0] code_q, code_d;
  dec_e              dec_q, dec_d;
  logic              trk_q, trk_d;
  logic [1:0]        clkdiv_q, clkdiv_d;
  logic              dcs_en_q, dcs_en_d;
  logic              dcs_reset_q, dcs_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic meas_start;
  logic meas_done;
  logic meas_hi;
  logic meas_lo;

  aibio_dqs_dcs_meas #(
    .AVG_W      (AVG_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_meas (
    .clk      (clk),
    .reset    (reset),
    .start    (meas_start),
    .dc_gt_50 (dc_gt_50),
    .chopen   (chopen),
    .done     (meas_done),
    .hi       (meas_hi),
    .lo       (meas_lo)
  );

  always_comb begin
    state_d     = state_q;
    srst_cnt_d  = srst_cnt_q;
    bit_d       = bit_q;
    code_d      = code_q;
    dec_d       = dec_q;
    trk_d       = trk_q;
    clkdiv_d    = clkdiv_q;
    dcs_en_d    = dcs_en_q;
    dcs_reset_d = dcs_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    meas_start  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cal_start) begin
          clkdiv_d    = cfg_clkdiv;
          done_d      = 1'b0;
          err_d       = 1'b0;
          trk_d       = 1'b0;
          dcs_en_d    = 1'b1;
          dcs_reset_d = 1'b1;
          busy_d      = 1'b1;
          srst_cnt_d  = '0;
          state_d     = SRST;
        end
      end

      SRST: begin
        srst_cnt_d = srst_cnt_q + 2'd1;
        if (srst_cnt_q == 2'(SRST_CYC - 1)) begin
          bit_d       = IW'(CODE_W - 1);
          code_d      = CODE_MID;
          dcs_reset_d = 1'b0;
          meas_start  = 1'b1;
          state_d     = MEAS;
        end
      end

      // MEAS (search) and TRACK (tracking) measure identically; trk_q tells
      // DECIDE which update rule applies.
      MEAS, TRACK: begin
        if (meas_done) begin
          dec_d   = meas_hi ? DEC_HI : (meas_lo ? DEC_LO : DEC_TIE);
          state_d = DECIDE;
        end
      end

      DECIDE: begin
        if (!trk_q) begin
          if (dec_q == DEC_HI) code_d[bit_q] = 1'b0;
          if (bit_q != '0) begin
            code_d[bit_q - IW'(1)] = 1'b1;
            bit_d      = bit_q - IW'(1);
            meas_start = 1'b1;
            state_d    = MEAS;
          end else begin
            state_d = DONE;
          end
        end else begin
          if ((dec_q == DEC_HI) && (code_q != '0)) code_d = code_q - CODE_W'(1);
          if ((dec_q == DEC_LO) && (code_q != '1)) code_d = code_q + CODE_W'(1);
          if (track_en) begin
            meas_start = 1'b1;
            state_d    = TRACK;
          end else begin
            dcs_en_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
      end

      // Sensor stays enabled through DONE so tracking starts without an
      // enable glitch; it drops only on the way back to IDLE.
      DONE: begin
        done_d = 1'b1;
        err_d  = (code_q == '0) || (code_q == '1);
        if (track_en) begin
          trk_d      = 1'b1;
          meas_start = 1'b1;
          state_d    = TRACK;
        end else begin
          dcs_en_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      srst_cnt_q  <= '0;
      bit_q       <= '0;
      code_q      <= CODE_MID;
      dec_q       <= DEC_TIE;
      trk_q       <= 1'b0;
      clkdiv_q    <= '0;
      dcs_en_q    <= 1'b0;
      dcs_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      srst_cnt_q  <= srst_cnt_d;
      bit_q       <= bit_d;
      code_q      <= code_d;
      dec_q       <= dec_d;
      trk_q       <= trk_d;
      clkdiv_q    <= clkdiv_d;
      dcs_en_q    <= dcs_en_d;
      dcs_reset_q <= dcs_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign dcs_en     = dcs_en_q;
  assign dcs_reset  = dcs_reset_q;
  assign dcs_clkdiv = clkdiv_q;
  assign dcc_code   = code_q;
  assign cal_busy   = busy_q;
  assign cal_done   = done_q;
  assign cal_err    = err_q;

endmodule

// File: tb/tb_aibio_dqs_dcs_cal_ctrl.sv
// Bench for aibio_dqs_dcs_cal_ctrl: a timeline model (segment + position
// arithmetic) checked against every output each cycle, plus directed scenarios
// with hand-computed expected codes and latencies.
module tb_aibio_dqs_dcs_cal_ctrl;

  localparam int CODE_W = 7;
  localparam int AVG_W  = 4;
  localparam int SETTLE = 16;
  localparam int N      = 1 << AVG_W;
  localparam int MLEN   = 2 * SETTLE + N;   // cycles of sensing per measurement
  localparam int CMAX   = (1 << CODE_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cal_start = 1'b0;
  logic              track_en = 1'b0;
  logic [1:0]        cfg_clkdiv = 2'd0;
  logic              dc_gt_50;
  logic              dcs_en, dcs_reset, chopen, cal_busy, cal_done, cal_err;
  logic [1:0]        dcs_clkdiv;
  logic [CODE_W-1:0] dcc_code;

  // Sensor model: 0 = threshold on code, 1 = tied 1, 2 = tied 0, 3 = follows chop (tie)
  int sns_mode = 0;
  int sns_thr  = 45;
  assign dc_gt_50 = (sns_mode == 1) ? 1'b1 :
                    (sns_mode == 2) ? 1'b0 :
                    (sns_mode == 3) ? chopen :
                    (int'(dcc_code) >= sns_thr);

  aibio_dqs_dcs_cal_ctrl #(
    .CODE_W     (CODE_W),
    .AVG_W      (AVG_W),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cal_start  (cal_start),
    .track_en   (track_en),
    .cfg_clkdiv (cfg_clkdiv),
    .dc_gt_50   (dc_gt_50),
    .dcs_en     (dcs_en),
    .dcs_reset  (dcs_reset),
    .chopen     (chopen),
    .dcs_clkdiv (dcs_clkdiv),
    .dcc_code   (dcc_code),
    .cal_busy   (cal_busy),
    .cal_done   (cal_done),
    .cal_err    (cal_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  localparam int SEG_IDLE = 0, SEG_SRST = 1, SEG_MEAS = 2, SEG_DONE = 3;

  function automatic bit in_win(input int p);
    return ((p >= SETTLE) && (p < SETTLE + N/2)) || ((p >= 2*SETTLE + N/2) && (p < MLEN));
  endfunction

  initial begin
    int m_valid, m_seg, m_p, m_k, m_ones, m_trk;
    int m_code, m_div, m_busy, m_done, m_err, m_en, m_rst, m_chop;
    bit hi, lo;
    m_valid = 0; m_seg = SEG_IDLE; m_p = 0; m_k = 0; m_ones = 0; m_trk = 0;
    m_code = 0; m_div = 0; m_busy = 0; m_done = 0; m_err = 0; m_en = 0; m_rst = 0; m_chop = 0;
    forever begin
      @(negedge clk);
      if (m_valid != 0) begin
        chk("dcc_code",   int'(dcc_code),   m_code);
        chk("cal_busy",   int'(cal_busy),   m_busy);
        chk("cal_done",   int'(cal_done),   m_done);
        chk("cal_err",    int'(cal_err),    m_err);
        chk("dcs_en",     int'(dcs_en),     m_en);
        chk("dcs_reset",  int'(dcs_reset),  m_rst);
        chk("chopen",     int'(chopen),     m_chop);
        chk("dcs_clkdiv", int'(dcs_clkdiv), m_div);
      end
      // advance to the values expected after the coming edge
      if (reset) begin
        m_valid = 1; m_seg = SEG_IDLE; m_p = 0; m_ones = 0; m_trk = 0;
        m_code = 1 << (CODE_W - 1); m_div = 0;
        m_busy = 0; m_done = 0; m_err = 0; m_en = 0; m_rst = 0; m_chop = 0;
      end else if (m_valid != 0) begin
        case (m_seg)
          SEG_IDLE: if (cal_start) begin
            m_div = int'(cfg_clkdiv); m_done = 0; m_err = 0; m_trk = 0;
            m_en = 1; m_rst = 1; m_busy = 1; m_seg = SEG_SRST; m_p = 0;
          end
          SEG_SRST: begin
            if (m_p == 3) begin
              m_rst = 0; m_k = CODE_W - 1; m_code = 1 << m_k;
              m_seg = SEG_MEAS; m_p = 0; m_ones = 0;
            end else m_p++;
          end
          SEG_MEAS: begin
            if (m_p < MLEN) begin
              if (in_win(m_p)) m_ones += int'(dc_gt_50);
              m_p++;
              m_chop = ((m_p >= SETTLE + N/2) && (m_p < MLEN)) ? 1 : 0;
            end else begin
              hi = m_ones > N/2;
              lo = m_ones < N/2;
              m_ones = 0; m_p = 0;
              if (m_trk == 0) begin
                if (hi) m_code -= (1 << m_k);
                if (m_k > 0) begin
                  m_k--;
                  m_code += (1 << m_k);
                end else m_seg = SEG_DONE;
              end else begin
                if (hi && m_code > 0) m_code--;
                else if (lo && m_code < CMAX) m_code++;
                if (!track_en) begin
                  m_seg = SEG_IDLE; m_en = 0; m_busy = 0;
                end
              end
            end
          end
          SEG_DONE: begin
            m_done = 1;
            m_err = (m_code == 0 || m_code == CMAX) ? 1 : 0;
            if (track_en) begin
              m_trk = 1; m_seg = SEG_MEAS; m_p = 0; m_ones = 0;
            end else begin
              m_en = 0; m_busy = 0; m_seg = SEG_IDLE;
            end
          end
          default: m_seg = SEG_IDLE;
        endcase
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Returns latency counted from the cycle presenting cal_start (cycle 0) to
  // the first cycle with cal_done high.
  task automatic run_cal(input bit pulses, output int lat);
    int e;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    e = 0;
    while (!cal_done && e < 1000) begin
      if (pulses && (e == 10 || e == 200)) cal_start = 1'b1;
      if (pulses && e == 100) cfg_clkdiv = 2'd1;
      tick();
      cal_start = 1'b0;
      e++;
    end
    if (e >= 1000) chk("cal_done_timeout", 0, 1);
    lat = e + 1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int e;
    e = 0;
    while (cal_busy && e < budget) begin
      tick();
      e++;
    end
    chk(name, int'(cal_busy), 0);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_code", int'(dcc_code), 64);
    chk("rst_busy", int'(cal_busy), 0);
    chk("rst_chop", int'(chopen), 0);
    chk("rst_en", int'(dcs_en), 0);
    chk("rst_div", int'(dcs_clkdiv), 0);
    reset = 1'b0;
    tick();

    // Threshold 45 search, with ignored start pulses and cfg change mid-search
    sns_mode = 0; sns_thr = 45; cfg_clkdiv = 2'd2;
    run_cal(1'b1, lat);
    chk("a_latency", lat, 349);
    chk("a_code", int'(dcc_code), 44);
    chk("a_err", int'(cal_err), 0);
    chk("a_div_kept", int'(dcs_clkdiv), 2);
    tick();
    chk("a_en_off", int'(dcs_en), 0);
    chk("a_busy_off", int'(cal_busy), 0);
    chk("a_done_held", int'(cal_done), 1);

    // Saturating searches
    sns_mode = 1;
    run_cal(1'b0, lat);
    chk("one_code", int'(dcc_code), 0);
    chk("one_err", int'(cal_err), 1);
    sns_mode = 2;
    run_cal(1'b0, lat);
    chk("zero_code", int'(dcc_code), 127);
    chk("zero_err", int'(cal_err), 1);
    chk("zero_latency", lat, 349);

    // Reset during the third measurement (chop already on)
    sns_mode = 0; sns_thr = 45;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    repeat (4 + 2*49 + 29) tick();
    chk("mid_chop_pre", int'(chopen), 1);
    reset = 1'b1;
    tick();
    chk("mid_code", int'(dcc_code), 64);
    chk("mid_busy", int'(cal_busy), 0);
    chk("mid_chop", int'(chopen), 0);
    chk("mid_err", int'(cal_err), 0);
    reset = 1'b0;
    tick();
    run_cal(1'b0, lat);
    chk("mid_rerun_code", int'(dcc_code), 44);
    chk("mid_rerun_latency", lat, 349);

    // Tracking toward threshold 50
    track_en = 1'b1;
    run_cal(1'b0, lat);
    chk("trk_search_code", int'(dcc_code), 44);
    sns_thr = 50;
    repeat (48) tick();
    chk("trk_hold_48", int'(dcc_code), 44);
    tick();
    chk("trk_step_49", int'(dcc_code), 45);
    repeat (245) tick();
    chk("trk_reach_50", int'(dcc_code), 50);
    repeat (49) tick();
    chk("trk_dither_49", int'(dcc_code), 49);
    repeat (49) tick();
    chk("trk_dither_50", int'(dcc_code), 50);
    chk("trk_busy", int'(cal_busy), 1);
    chk("trk_done", int'(cal_done), 1);
    track_en = 1'b0;
    wait_idle("trk_exit", 60);
    chk("trk_exit_done", int'(cal_done), 1);
    chk("trk_exit_en", int'(dcs_en), 0);

    // Tracking with a tie sensor holds the code
    track_en = 1'b1; sns_thr = 45;
    run_cal(1'b0, lat);
    sns_mode = 3;
    repeat (3*49) tick();
    chk("tie_code", int'(dcc_code), 44);
    chk("tie_busy", int'(cal_busy), 1);
    track_en = 1'b0;
    wait_idle("tie_exit", 60);
    chk("tie_final", int'(dcc_code), 44);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
